// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment display: segment bit
// positions, hex glyph patterns and the frame register layout.
package disp_pkg;

  localparam int MAX_DIGITS = 8;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Glyphs are {g,f,e,d,c,b,a}, 1 = segment lit.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] digits;
    logic [MAX_DIGITS-1:0]   dp;
    logic [MAX_DIGITS-1:0]   blink;
    logic                    lz;
  } frame_t;

endpackage

// File: rtl/scan_display_n_if.sv
// Control and display bus of the scanned display; master is the system side,
// slave is the display controller.
interface scan_display_n_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    power_on;
  logic                    scan_tick;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_en;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output power_on, scan_tick, digits, dp_mask, blink_mask, lz_en,
    input  seg, an, frame_start
  );

  modport slave (
    input  power_on, scan_tick, digits, dp_mask, blink_mask, lz_en,
    output seg, an, frame_start
  );
endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to seven-segment decoder, active-high segments.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [6:0] glyph_s;

  // Nibble to glyph lookup
  always_comb begin
    glyph_s = GLYPH_0;
    case (nibble)
      4'h0:    glyph_s = GLYPH_0;
      4'h1:    glyph_s = GLYPH_1;
      4'h2:    glyph_s = GLYPH_2;
      4'h3:    glyph_s = GLYPH_3;
      4'h4:    glyph_s = GLYPH_4;
      4'h5:    glyph_s = GLYPH_5;
      4'h6:    glyph_s = GLYPH_6;
      4'h7:    glyph_s = GLYPH_7;
      4'h8:    glyph_s = GLYPH_8;
      4'h9:    glyph_s = GLYPH_9;
      4'hA:    glyph_s = GLYPH_A;
      4'hB:    glyph_s = GLYPH_B;
      4'hC:    glyph_s = GLYPH_C;
      4'hD:    glyph_s = GLYPH_D;
      4'hE:    glyph_s = GLYPH_E;
      4'hF:    glyph_s = GLYPH_F;
      default: glyph_s = GLYPH_0;
    endcase
  end

  // Place glyph and decimal point at their segment positions
  always_comb begin
    seg              = 8'h00;
    seg[SEG_G:SEG_A] = glyph_s;
    seg[SEG_DP]      = dp;
  end

endmodule

// File: rtl/scan_display_n.sv
// Multiplexed N-digit seven-segment scanner with tear-free frame latch,
// per-digit blink, leading-zero suppression and registered outputs.
module scan_display_n
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 2500,
  parameter int ACTIVE_LOW = 1
) (
  input logic              clk,
  input logic              rst,
  scan_display_n_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  // XOR masks that turn internal active-high values into output polarity
  localparam logic [7:0] SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
      (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [IDX_W-1:0]      idx_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  phase_r;
  logic                  live_r;
  frame_t                frame_r;
  logic [7:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  fs_r;

  logic                  tick_s;
  logic [IDX_W-1:0]      idx_nx_s;
  frame_t                frame_in_s;
  frame_t                frame_sel_s;
  logic [3:0]            nib_s;
  logic                  dp_s;
  logic                  upper_zero_s;
  logic                  blank_s;
  logic [7:0]            glyph_s;
  logic [7:0]            seg_on_s;
  logic [NUM_DIGITS-1:0] an_on_s;

  // live_r masks the scan tick on the first edge after reset release
  assign tick_s = bus.scan_tick & bus.power_on & live_r;

  // Next scan index with wrap
  always_comb begin
    idx_nx_s = IDX_ZERO;
    if (idx_r == IDX_LAST) begin
      idx_nx_s = IDX_ZERO;
    end else begin
      idx_nx_s = idx_r + IDX_W'(1);
    end
  end

  // Frame contents for the digit being selected; digit 0 sees the new frame
  always_comb begin
    frame_in_s        = '0;
    frame_in_s.digits = (4*MAX_DIGITS)'(bus.digits);
    frame_in_s.dp     = MAX_DIGITS'(bus.dp_mask);
    frame_in_s.blink  = MAX_DIGITS'(bus.blink_mask);
    frame_in_s.lz     = bus.lz_en;
    if (idx_r == IDX_ZERO) begin
      frame_sel_s = frame_in_s;
    end else begin
      frame_sel_s = frame_r;
    end
  end

  // Blanking: blink phase, or a zero with only zeros above it
  always_comb begin
    nib_s        = frame_sel_s.digits[{idx_r, 2'b00} +: 4];
    dp_s         = frame_sel_s.dp[idx_r];
    upper_zero_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_zero_s = upper_zero_s &
                     ((i < int'(idx_r)) | (frame_sel_s.digits[4*i +: 4] == 4'h0));
    end
    blank_s = (frame_sel_s.blink[idx_r] & phase_r) |
              (frame_sel_s.lz & upper_zero_s & (idx_r != IDX_ZERO));
  end

  hex7seg u_hex7seg (
    .nibble (nib_s),
    .dp     (dp_s),
    .seg    (glyph_s)
  );

  // Active-high segment and anode patterns before polarity
  always_comb begin
    an_on_s = NUM_DIGITS'(1) << idx_r;
    if (blank_s) begin
      seg_on_s = 8'h00;
    end else begin
      seg_on_s = glyph_s;
    end
  end

  // Scan index, blink counter/phase and reset-release qualifier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r   <= IDX_ZERO;
      cnt_r   <= CNT_ZERO;
      phase_r <= 1'b0;
      live_r  <= 1'b0;
    end else begin
      live_r <= 1'b1;
      if (!bus.power_on) begin
        idx_r   <= IDX_ZERO;
        cnt_r   <= CNT_ZERO;
        phase_r <= 1'b0;
      end else if (tick_s) begin
        idx_r <= idx_nx_s;
        if (cnt_r == CNT_LAST) begin
          cnt_r   <= CNT_ZERO;
          phase_r <= ~phase_r;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  // Frame latch when digit 0 is selected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_r <= '0;
    end else if (tick_s && (idx_r == IDX_ZERO)) begin
      frame_r <= frame_in_s;
    end
  end

  // Output register; power-off wins over a coincident tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= SEG_OFF;
      an_r  <= AN_OFF;
      fs_r  <= 1'b0;
    end else if (!bus.power_on) begin
      seg_r <= SEG_OFF;
      an_r  <= AN_OFF;
      fs_r  <= 1'b0;
    end else if (tick_s) begin
      seg_r <= seg_on_s ^ SEG_OFF;
      an_r  <= an_on_s ^ AN_OFF;
      fs_r  <= (idx_r == IDX_ZERO);
    end else begin
      fs_r  <= 1'b0;
    end
  end

  assign bus.seg         = seg_r;
  assign bus.an          = an_r;
  assign bus.frame_start = fs_r;

endmodule
